dly_var_iq: RTL and testbench

- Programmable I/Q sample delay line with a valid strobe.
- Sits in the feedback-alignment path of the DPD. It delays the TX reference I/Q stream by a runtime-loaded number of samples so that it lines up with the observation-receiver feedback before the fixed pipeline delays and the coefficient estimator.
- Storage is a circular buffer, not a register chain, so the delay can reach hundreds of samples.

---
 rtl/dpd_pkg.sv | 12 +
 rtl/dpram_sdp.sv | 29 ++
 rtl/dly_var_iq.sv | 117 +++++++++++
 tb/tb_dly_var_iq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dpd_pkg.sv
// Shared DPD constants and small helpers.
package dpd_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned BUF_AW   = 8;

    // Limit a requested delay to the largest delay the buffer can serve.
    function automatic int unsigned clampdelay(input int unsigned d, input int unsigned dmax);
        return (d > dmax) ? dmax : d;
    endfunction

endpackage

// File: rtl/dpram_sdp.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module dpram_sdp #(
    parameter int unsigned W2 = 32,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W2-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W2-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W2-1:0] mem [DEPTH];

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dly_var_iq.sv
// Programmable I/Q sample delay line on a circular buffer; delay counts samples, not clocks.
module dly_var_iq
    import dpd_pkg::*;
#(
    parameter int unsigned W    = SAMPLE_W,
    parameter int unsigned AW   = BUF_AW,
    parameter int unsigned DMAX = (2 ** AW) - 1
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic [W-1:0]  i_in,
    input  logic [W-1:0]  q_in,
    input  logic          valid_in,
    input  logic [AW-1:0] delay,
    input  logic          delay_ld,
    output logic [W-1:0]  i_out,
    output logic [W-1:0]  q_out,
    output logic          valid_out,
    output logic          busy,
    output logic [AW-1:0] delay_cur
);

    localparam int unsigned   W2       = 2 * W;
    localparam logic [AW-1:0] FILL_MAX = '1;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_BYP,
        SRC_RAM
    } src_e;

    src_e          src_q;
    logic [W2-1:0] byp_q;
    logic [W2-1:0] ram_rd;
    logic [W2-1:0] out_word_c;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] fill;
    logic [AW-1:0] delay_eff;
    logic [AW-1:0] rd_addr_c;
    logic [AW-1:0] fill_nxt_c;
    logic [AW-1:0] delay_nxt_c;
    logic          hist_ok_c;
    logic          rd_en_c;

    // Read address, history check and next-state values for fill and delay.
    always_comb begin
        rd_addr_c   = wr_ptr - delay_eff;
        hist_ok_c   = (fill >= delay_eff);
        rd_en_c     = valid_in && (delay_eff != '0) && hist_ok_c;
        fill_nxt_c  = fill;
        delay_nxt_c = delay_eff;
        if (valid_in && (fill != FILL_MAX)) begin
            fill_nxt_c = fill + AW'(1);
        end
        if (delay_ld) begin
            delay_nxt_c = AW'(clampdelay(32'(delay), DMAX));
        end
    end

    // Pointer, fill, delay and output-source pipeline; a sample arriving with
    // delay_ld still sees the old delay_eff because selection uses the register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr    <= '0;
            fill      <= '0;
            delay_eff <= '0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            src_q     <= SRC_ZERO;
            byp_q     <= '0;
        end else begin
            valid_out <= valid_in;
            fill      <= fill_nxt_c;
            delay_eff <= delay_nxt_c;
            busy      <= (fill_nxt_c < delay_nxt_c);
            if (valid_in) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (delay_eff == '0) begin
                    src_q <= SRC_BYP;
                    byp_q <= {i_in, q_in};
                end else if (hist_ok_c) begin
                    src_q <= SRC_RAM;
                end else begin
                    src_q <= SRC_ZERO;
                end
            end
        end
    end

    dpram_sdp #(
        .W2 (W2),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (valid_in),
        .waddr (wr_ptr),
        .wdata ({i_in, q_in}),
        .re    (rd_en_c),
        .raddr (rd_addr_c),
        .rdata (ram_rd)
    );

    // All mux inputs and the select only change on valid samples, so the output holds otherwise.
    always_comb begin
        out_word_c = '0;
        case (src_q)
            SRC_BYP: out_word_c = byp_q;
            SRC_RAM: out_word_c = ram_rd;
            default: out_word_c = '0;
        endcase
    end

    assign i_out     = out_word_c[W2-1:W];
    assign q_out     = out_word_c[W-1:0];
    assign delay_cur = delay_eff;

endmodule

// File: tb/tb_dly_var_iq.sv
// Directed bench for dly_var_iq: main AW=8 instance plus two AW=4 instances for wrap and clamp.
module tb_dly_var_iq;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [15:0] i_in, q_in, i_out, q_out;
    logic        valid_in, valid_out, delay_ld, busy;
    logic [7:0]  delay, delay_cur;

    logic [15:0] s_i_in, s_q_in, s_i_out, s_q_out, c_i_out, c_q_out;
    logic        s_valid_in, s_valid_out, s_delay_ld, s_busy, c_valid_out, c_busy;
    logic [3:0]  s_delay, s_delay_cur, c_delay_cur;

    int n_chk  = 0;
    int n_pass = 0;
    int hist[$];
    int cnt    = 0;
    int d_eff  = 0;
    int last_i = 0;

    always #5 clk = ~clk;

    dly_var_iq u_dut (
        .clk(clk), .reset_b(reset_b), .i_in(i_in), .q_in(q_in), .valid_in(valid_in),
        .delay(delay), .delay_ld(delay_ld), .i_out(i_out), .q_out(q_out),
        .valid_out(valid_out), .busy(busy), .delay_cur(delay_cur)
    );

    dly_var_iq #(.W(16), .AW(4)) u_small (
        .clk(clk), .reset_b(reset_b), .i_in(s_i_in), .q_in(s_q_in), .valid_in(s_valid_in),
        .delay(s_delay), .delay_ld(s_delay_ld), .i_out(s_i_out), .q_out(s_q_out),
        .valid_out(s_valid_out), .busy(s_busy), .delay_cur(s_delay_cur)
    );

    dly_var_iq #(.W(16), .AW(4), .DMAX(10)) u_clamp (
        .clk(clk), .reset_b(reset_b), .i_in(s_i_in), .q_in(s_q_in), .valid_in(s_valid_in),
        .delay(s_delay), .delay_ld(s_delay_ld), .i_out(c_i_out), .q_out(c_q_out),
        .valid_out(c_valid_out), .busy(c_busy), .delay_cur(c_delay_cur)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One valid sample on the main instance; expected output from the sample-history model.
    task automatic send(input int iv, input bit ld, input int d);
        int f;
        int e;
        int f2;
        @(negedge clk);
        valid_in = 1'b1;
        i_in     = 16'(iv);
        q_in     = 16'(-iv);
        delay_ld = ld;
        delay    = 8'(d);
        f = (cnt > DEPTH - 1) ? DEPTH - 1 : cnt;
        if (d_eff == 0)     e = iv;
        else if (f < d_eff) e = 0;
        else                e = hist[cnt - d_eff];
        hist.push_back(iv);
        cnt++;
        if (ld) d_eff = d;
        f2 = (cnt > DEPTH - 1) ? DEPTH - 1 : cnt;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        delay_ld = 1'b0;
        check("valid_out", {31'd0, valid_out}, 32'd1);
        check("i_out", {16'd0, i_out}, {16'd0, 16'(e)});
        check("q_out", {16'd0, q_out}, {16'd0, 16'(-e)});
        check("busy", {31'd0, busy}, {31'd0, f2 < d_eff});
        last_i = e;
    endtask

    task automatic idle(input bit ld, input int d);
        int f;
        @(negedge clk);
        valid_in = 1'b0;
        delay_ld = ld;
        delay    = 8'(d);
        if (ld) d_eff = d;
        f = (cnt > DEPTH - 1) ? DEPTH - 1 : cnt;
        @(posedge clk);
        #1;
        delay_ld = 1'b0;
        check("idle_valid", {31'd0, valid_out}, 32'd0);
        check("idle_hold", {16'd0, i_out}, {16'd0, 16'(last_i)});
        check("idle_busy", {31'd0, busy}, {31'd0, f < d_eff});
    endtask

    // Asynchronous reset between clock edges; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_b = 1'b0;
        #1;
        check("rst_i", {16'd0, i_out}, 32'd0);
        check("rst_q", {16'd0, q_out}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_delay", {24'd0, delay_cur}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_b = 1'b1;
        hist.delete();
        cnt    = 0;
        d_eff  = 0;
        last_i = 0;
    endtask

    task automatic s_send(input int k);
        int es;
        int ec;
        @(negedge clk);
        s_valid_in = 1'b1;
        s_i_in     = 16'(k);
        s_q_in     = 16'(-k);
        es = (k >= 16) ? k - 15 : 0;
        ec = (k >= 11) ? k - 10 : 0;
        @(posedge clk);
        #1;
        s_valid_in = 1'b0;
        check("small_valid", {31'd0, s_valid_out}, 32'd1);
        check("small_i", {16'd0, s_i_out}, {16'd0, 16'(es)});
        check("small_q", {16'd0, s_q_out}, {16'd0, 16'(-es)});
        check("clamp_i", {16'd0, c_i_out}, {16'd0, 16'(ec)});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_b    = 1'b0;
        valid_in   = 1'b0;
        i_in       = '0;
        q_in       = '0;
        delay      = '0;
        delay_ld   = 1'b0;
        s_valid_in = 1'b0;
        s_i_in     = '0;
        s_q_in     = '0;
        s_delay    = '0;
        s_delay_ld = 1'b0;
        do_reset();

        // Delay 5 on a continuous ramp.
        idle(1'b1, 5);
        check("t1_delay_cur", {24'd0, delay_cur}, 32'd5);
        for (int k = 1; k <= 5; k++) send(k, 1'b0, 0);
        send(6, 1'b0, 0);
        check("t1_out6", {16'd0, i_out}, 32'd1);
        for (int k = 7; k <= 20; k++) send(k, 1'b0, 0);
        check("t1_out20", {16'd0, i_out}, 32'd15);
        idle(1'b0, 0);

        // Zero delay uses the bypass.
        do_reset();
        idle(1'b1, 0);
        for (int k = 100; k <= 110; k++) send(k, 1'b0, 0);
        check("t2_out110", {16'd0, i_out}, 32'd110);

        // Delay 3 with gapped input.
        do_reset();
        idle(1'b1, 3);
        for (int k = 1; k <= 10; k++) begin
            send(k, 1'b0, 0);
            if (k == 4) check("t3_out4", {16'd0, i_out}, 32'd1);
            idle(1'b0, 0);
        end

        // Mid-stream delay changes, loads coincide with samples.
        do_reset();
        idle(1'b1, 4);
        for (int n = 1; n <= 60; n++) begin
            send(n, (n == 30) || (n == 50), (n == 30) ? 2 : 8);
            if (n == 30) check("t5_same_cycle_30", {16'd0, i_out}, 32'd26);
            if (n == 31) check("t5_out31", {16'd0, i_out}, 32'd29);
            if (n == 50) check("t5_same_cycle_50", {16'd0, i_out}, 32'd48);
            if (n == 51) check("t5_out51", {16'd0, i_out}, 32'd43);
        end

        // Reset mid-stream, then rebuild history with delay 4.
        for (int n = 61; n <= 70; n++) send(n, 1'b0, 0);
        do_reset();
        idle(1'b1, 4);
        for (int k = 0; k < 5; k++) send(200 + k, 1'b0, 0);
        check("t6_first_after_reset", {16'd0, i_out}, 32'd200);

        // AW=4 instances: max delay with pointer wrap, and clamped delay.
        @(negedge clk);
        s_delay_ld = 1'b1;
        s_delay    = 4'd15;
        @(posedge clk);
        #1;
        s_delay_ld = 1'b0;
        check("small_delay_cur", {28'd0, s_delay_cur}, 32'd15);
        check("clamp_delay_cur", {28'd0, c_delay_cur}, 32'd10);
        check("small_busy", {31'd0, s_busy}, 32'd1);
        for (int k = 1; k <= 40; k++) s_send(k);
        check("small_busy_end", {31'd0, s_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
